// File: rtl/if_stage_if.sv
// if_stage_if: groups the instruction-memory fetch bus, the execute redirect
// and the decode-side output slot of the fetch stage into one bundle.
// "master" is the fetch stage's view and "slave" is the surrounding
// memory/execute/decode environment.
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        inst_misalign;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_target,
        input  id_ready,
        output inst_valid,
        output inst,
        output inst_addr,
        output inst_misalign
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_target,
        output id_ready,
        input  inst_valid,
        input  inst,
        input  inst_addr,
        input  inst_misalign
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, keeps at most one fetch in
// flight, and hands fetched words to decode through a single-entry output
// slot. Execute redirects flush the slot and kill any fetch in flight.
// Optional macro IF_MISALIGN_CHK_EN: a redirect to a target that is not
// 4-byte aligned parks the stage in HALT and presents a NOP flagged with
// inst_misalign until an aligned redirect arrives. Without the macro the low
// two target bits are forced to zero and HALT is unreachable.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      r_state;
    state_t      w_stateNext;
    logic [63:0] r_pc;
    logic        r_kill;
    logic        r_haltPend;
    logic        r_instValid;
    logic [31:0] r_inst;
    logic [63:0] r_instAddr;
    logic        r_instMisalign;

    logic        w_slotFree;
    logic        w_reqValid;
    logic        w_fire;
    logic        w_load;
    logic        w_haltLoad;
    logic        w_haltExit;
    logic        w_mis;
    logic [63:0] w_target;

`ifdef IF_MISALIGN_CHK_EN
    assign w_target = bus.redirect_target;
    assign w_mis    = |bus.redirect_target[1:0];
`else
    assign w_target = bus.redirect_target & ~64'h3;
    assign w_mis    = 1'b0;
`endif

    assign w_slotFree = !r_instValid || bus.id_ready;
    assign w_fire     = w_reqValid && bus.imem_req_ready;
    assign w_load     = (r_state == S_WAIT) && bus.imem_resp_valid &&
                        !r_kill && !bus.redirect_valid;
    assign w_haltLoad = (w_stateNext == S_HALT) &&
                        ((r_state != S_HALT) || bus.redirect_valid);
    assign w_haltExit = (r_state == S_HALT) && (w_stateNext == S_REQ);

    assign bus.imem_req_valid = w_reqValid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = r_instValid;
    assign bus.inst           = r_inst;
    assign bus.inst_addr      = r_instAddr;
`ifdef IF_MISALIGN_CHK_EN
    assign bus.inst_misalign  = r_instMisalign;
`else
    assign bus.inst_misalign  = 1'b0;
`endif

    // State register: advance the fetch FSM, returning to REQ on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: redirects win; a misaligned target lands in HALT, either
    // immediately or once the single outstanding response has been absorbed.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    w_stateNext = w_mis ? S_HALT : S_REQ;
                end else if (w_fire) begin
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    if (bus.imem_resp_valid) begin
                        w_stateNext = w_mis ? S_HALT : S_REQ;
                    end
                end else if (bus.imem_resp_valid) begin
                    w_stateNext = (r_kill && r_haltPend) ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                if (bus.redirect_valid && !w_mis) begin
                    w_stateNext = S_REQ;
                end
            end
            default: w_stateNext = S_REQ;
        endcase
    end

    // Outputs: request only from REQ, into a free slot, never during a
    // redirect or while reset is held.
    always_comb begin
        w_reqValid = 1'b0;
        if ((r_state == S_REQ) && w_slotFree && !bus.redirect_valid && !rst) begin
            w_reqValid = 1'b1;
        end
    end

    // Datapath: PC, kill tracking and the decode output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_kill         <= 1'b0;
            r_haltPend     <= 1'b0;
            r_instValid    <= 1'b0;
            r_inst         <= 32'h0;
            r_instAddr     <= 64'h0;
            r_instMisalign <= 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= w_target;
            end else if (w_load) begin
                r_pc <= r_pc + 64'd4;
            end

            if (bus.redirect_valid && (r_state == S_WAIT) && !bus.imem_resp_valid) begin
                r_kill     <= 1'b1;
                r_haltPend <= w_mis;
            end else if ((r_state == S_WAIT) && bus.imem_resp_valid) begin
                r_kill     <= 1'b0;
                r_haltPend <= 1'b0;
            end

            if (w_haltLoad) begin
                r_instValid    <= 1'b1;
                r_inst         <= NOP_INST;
                r_instAddr     <= bus.redirect_valid ? w_target : r_pc;
                r_instMisalign <= 1'b1;
            end else if (bus.redirect_valid) begin
                r_instValid <= 1'b0;
                if (w_haltExit) begin
                    r_instMisalign <= 1'b0;
                end
            end else if (w_load) begin
                r_instValid <= 1'b1;
                r_inst      <= bus.imem_resp_data;
                r_instAddr  <= r_pc;
            end else if (bus.id_ready) begin
                r_instValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, cycle-by-cycle bench for if_stage. The bench plays
// instruction memory, execute and decode by hand; every expected value below
// is worked out from the fetch-stage behaviour, not read back from the DUT.
module tb_if_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC(64'h0000_0000_8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every environment-side input, then let combinational logic settle.
    task automatic applyStimulus(input logic rv, input logic [63:0] rt,
                                 input logic respV, input logic [31:0] respD,
                                 input logic idr, input logic rdy);
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.imem_resp_valid = respV;
        bus.imem_resp_data  = respD;
        bus.id_ready        = idr;
        bus.imem_req_ready  = rdy;
        #1;
    endtask

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset state
        tick();
        checkOutput("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        checkOutput("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("rst_inst", {32'h0, bus.inst}, 64'h0);
        checkOutput("rst_inst_addr", bus.inst_addr, 64'h0);
        checkOutput("rst_misalign", {63'h0, bus.inst_misalign}, 64'h0);
        checkOutput("rst_pc", bus.imem_req_addr, 64'h8000_0000);

        // First fetch: request in N, response in N+1, slot valid in N+2
        rst = 1'b0;
        #1;
        checkOutput("f1_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("f1_req_addr", bus.imem_req_addr, 64'h8000_0000);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h0010_0093, 1'b1, 1'b1);
        checkOutput("f1_wait_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("f1_inst_valid", {63'h0, bus.inst_valid}, 64'h1);
        checkOutput("f1_inst", {32'h0, bus.inst}, 64'h0010_0093);
        checkOutput("f1_inst_addr", bus.inst_addr, 64'h8000_0000);
        checkOutput("f2_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("f2_req_addr", bus.imem_req_addr, 64'h8000_0004);

        // Decode stalls for 5 cycles with the slot full
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
            checkOutput("stall_inst", {32'h0, bus.inst}, 64'h0010_0093);
            checkOutput("stall_inst_valid", {63'h0, bus.inst_valid}, 64'h1);
            tick();
            applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("unstall_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("unstall_req_addr", bus.imem_req_addr, 64'h8000_0004);

        // Redirect one cycle after acceptance; stale response arrives 3 cycles later
        tick();
        applyStimulus(1'b1, 64'h8000_0100, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("kill_slot_consumed", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("kill_redir_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("kill_wait1_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("kill_wait2_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        checkOutput("kill_resp_slot", {63'h0, bus.inst_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("kill_dropped_slot", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("tgt_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("tgt_req_addr", bus.imem_req_addr, 64'h8000_0100);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h0020_0113, 1'b1, 1'b1);
        checkOutput("tgt_wait_slot", {63'h0, bus.inst_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("tgt_inst_valid", {63'h0, bus.inst_valid}, 64'h1);
        checkOutput("tgt_inst", {32'h0, bus.inst}, 64'h0020_0113);
        checkOutput("tgt_inst_addr", bus.inst_addr, 64'h8000_0100);
        checkOutput("tgt_next_addr", bus.imem_req_addr, 64'h8000_0104);

        // Redirect in the same cycle as the response
        tick();
        applyStimulus(1'b1, 64'h8000_0200, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b1);
        checkOutput("same_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("same_slot", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("same_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("same_req_addr", bus.imem_req_addr, 64'h8000_0200);

        // Reset while in WAIT
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrst_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrst_pc", bus.imem_req_addr, 64'h8000_0000);
        checkOutput("wrst_slot", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("wrst_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h0030_0193, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrst_inst", {32'h0, bus.inst}, 64'h0030_0193);
        checkOutput("wrst_inst_addr", bus.inst_addr, 64'h8000_0000);

        // Redirect to a target with nonzero low bits
        applyStimulus(1'b1, 64'h8000_0102, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("mis_redir_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef IF_MISALIGN_CHK_EN
        checkOutput("halt_inst_valid", {63'h0, bus.inst_valid}, 64'h1);
        checkOutput("halt_inst", {32'h0, bus.inst}, 64'h0000_0013);
        checkOutput("halt_inst_addr", bus.inst_addr, 64'h8000_0102);
        checkOutput("halt_misalign", {63'h0, bus.inst_misalign}, 64'h1);
        checkOutput("halt_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("halt_consumed", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("halt_misalign_held", {63'h0, bus.inst_misalign}, 64'h1);
        checkOutput("halt_still_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        applyStimulus(1'b1, 64'h8000_0200, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("unhalt_misalign", {63'h0, bus.inst_misalign}, 64'h0);
        checkOutput("unhalt_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("unhalt_req_addr", bus.imem_req_addr, 64'h8000_0200);
`else
        checkOutput("align_slot", {63'h0, bus.inst_valid}, 64'h0);
        checkOutput("align_misalign", {63'h0, bus.inst_misalign}, 64'h0);
        checkOutput("align_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        checkOutput("align_req_addr", bus.imem_req_addr, 64'h8000_0100);
`endif

        // PC wraps past the top of the 64-bit space
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap_req_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 32'h0040_0213, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap_inst_addr", bus.inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_inst", {32'h0, bus.inst}, 64'h0040_0213);
        checkOutput("wrap_next_addr", bus.imem_req_addr, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
